// File: rtl/rsv_pkg.sv
// rsv_pkg: shared port-select encoding for the reservation/decode path.
// Revision 1.0
`default_nettype none

package rsv_pkg;

  typedef logic [2:0] rsv_sel_t;

  localparam rsv_sel_t SEL_N     = 3'b000;
  localparam rsv_sel_t SEL_E     = 3'b001;
  localparam rsv_sel_t SEL_S     = 3'b010;
  localparam rsv_sel_t SEL_W     = 3'b011;
  localparam rsv_sel_t SEL_LOCAL = 3'b100;
  localparam rsv_sel_t SEL_MIS   = 3'b101;

endpackage

`default_nettype wire

// File: rtl/rsv_route_calc.sv
// rsv_route_calc: combinational destination -> output-port select (XY, or YX with RSV_YX_ROUTE_EN).
// Revision 1.0
`default_nettype none

module rsv_route_calc
  import rsv_pkg::*;
#(
  parameter int X_W     = 3,
  parameter int Y_W     = 3,
  parameter int MESH_X  = 8,
  parameter int MESH_Y  = 8,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0
) (
  input  logic [X_W-1:0] i_dst_x,
  input  logic [Y_W-1:0] i_dst_y,
  output rsv_sel_t       o_sel
);

  localparam logic [31:0] c_MESH_X  = 32'(MESH_X);
  localparam logic [31:0] c_MESH_Y  = 32'(MESH_Y);
  localparam logic [31:0] c_LOCAL_X = 32'(LOCAL_X);
  localparam logic [31:0] c_LOCAL_Y = 32'(LOCAL_Y);

  // Widen to 32 bits so mesh bounds beyond the field range compare unsigned.
  logic [31:0] w_x;
  logic [31:0] w_y;
  logic        w_invalid;

  assign w_x       = 32'(i_dst_x);
  assign w_y       = 32'(i_dst_y);
  assign w_invalid = (w_x >= c_MESH_X) || (w_y >= c_MESH_Y);

  always_comb begin
    o_sel = SEL_LOCAL;
    if (w_invalid)              o_sel = SEL_MIS;
`ifdef RSV_YX_ROUTE_EN
    else if (w_y > c_LOCAL_Y)   o_sel = SEL_S;
    else if (w_y < c_LOCAL_Y)   o_sel = SEL_N;
    else if (w_x > c_LOCAL_X)   o_sel = SEL_E;
    else if (w_x < c_LOCAL_X)   o_sel = SEL_W;
`else
    else if (w_x > c_LOCAL_X)   o_sel = SEL_E;
    else if (w_x < c_LOCAL_X)   o_sel = SEL_W;
    else if (w_y > c_LOCAL_Y)   o_sel = SEL_S;
    else if (w_y < c_LOCAL_Y)   o_sel = SEL_N;
`endif
    else                        o_sel = SEL_LOCAL;
  end

endmodule

`default_nettype wire

// File: rtl/rsv_route_stage.sv
// rsv_route_stage: flit input FIFO storing a per-flit route select computed at enqueue.
// Config macro: RSV_YX_ROUTE_EN (YX routing order). Revision 1.0
`default_nettype none

module rsv_route_stage
  import rsv_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int X_W     = 3,
  parameter int Y_W     = 3,
  parameter int MESH_X  = 8,
  parameter int MESH_Y  = 8,
  parameter int LOCAL_X = 0,
  parameter int LOCAL_Y = 0,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_flit,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_flit,
  output rsv_sel_t                 out_sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_DEPTH = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem     [DEPTH];
  rsv_sel_t         r_sel_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_occ;

  logic             w_push;
  logic             w_pop;
  logic             w_not_empty;
  rsv_sel_t         w_in_sel;

  rsv_route_calc #(
    .X_W     (X_W),
    .Y_W     (Y_W),
    .MESH_X  (MESH_X),
    .MESH_Y  (MESH_Y),
    .LOCAL_X (LOCAL_X),
    .LOCAL_Y (LOCAL_Y)
  ) u_route_calc (
    .i_dst_x (in_flit[X_W+Y_W-1:Y_W]),
    .i_dst_y (in_flit[Y_W-1:0]),
    .o_sel   (w_in_sel)
  );

  assign w_not_empty = (r_occ != '0);
  assign in_ready    = (r_occ != c_DEPTH);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = w_not_empty && out_ready;

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr]     <= in_flit;
      r_sel_mem[r_wptr] <= w_in_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
      else if (w_pop && !w_push) r_occ <= r_occ - 1'b1;
    end
  end

  assign out_valid = w_not_empty;
  assign out_flit  = w_not_empty ? r_mem[r_rptr]     : '0;
  assign out_sel   = w_not_empty ? r_sel_mem[r_rptr] : SEL_N;
  assign occupancy = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_rsv_route_stage.sv
// tb_rsv_route_stage: directed self-checking bench for rsv_route_stage (LOCAL=(3,3), DEPTH=4).
// Revision 1.0
`default_nettype none

module tb_rsv_route_stage;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] in_flit;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_flit;
  logic [2:0]       out_sel;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       occupancy;

  int checks = 0;
  int errors = 0;

  rsv_route_stage #(
    .WIDTH   (WIDTH),
    .X_W     (4),
    .Y_W     (4),
    .MESH_X  (8),
    .MESH_Y  (8),
    .LOCAL_X (3),
    .LOCAL_Y (3),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [WIDTH-1:0] mk(input logic [7:0] id, input logic [3:0] x, input logic [3:0] y);
    return {id, x, y};
  endfunction

  logic [3:0] rt_x [6] = '{4'd5, 4'd1, 4'd3, 4'd3, 4'd3, 4'd9};
  logic [3:0] rt_y [6] = '{4'd1, 4'd6, 4'd6, 4'd0, 4'd3, 4'd2};
`ifdef RSV_YX_ROUTE_EN
  logic [2:0] rt_sel [6] = '{3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b101};
`else
  logic [2:0] rt_sel [6] = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b100, 3'b101};
`endif

  task automatic test_reset;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_flit = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_flit !== 16'h0 || out_sel !== 3'b000) begin
      errors++;
      $display("FAIL reset_init: occ=%0d ov=%b ir=%b flit=%h sel=%b, want 0 0 1 0000 000",
               occupancy, out_valid, in_ready, out_flit, out_sel);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_flit = mk(8'h01 + 8'(i), 4'd5, 4'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd3 || out_sel !== 3'b001) begin
      errors++;
      $display("FAIL reset_prefill: occ=%0d sel=%b, want 3 001", occupancy, out_sel);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_flit !== 16'h0 || out_sel !== 3'b000) begin
      errors++;
      $display("FAIL reset_midstream: occ=%0d ov=%b ir=%b flit=%h sel=%b, want 0 0 1 0000 000",
               occupancy, out_valid, in_ready, out_flit, out_sel);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_routing;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_flit = mk(8'h10 + 8'(i), rt_x[i], rt_y[i]);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sel !== rt_sel[i] || out_flit !== mk(8'h10 + 8'(i), rt_x[i], rt_y[i])) begin
        errors++;
        $display("FAIL route_%0d: ov=%b sel=%b flit=%h, want 1 %b %h", i, out_valid, out_sel,
                 out_flit, rt_sel[i], mk(8'h10 + 8'(i), rt_x[i], rt_y[i]));
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL route_drain: ov=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_fill_wrap;
    for (int rep = 0; rep < 3; rep++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        in_valid = 1'b1; in_flit = mk(8'h20 + 8'(rep * 4 + i), 4'd3, 4'd3);
      end
      @(negedge clk);
      in_flit = mk(8'hEE, 4'd3, 4'd3);
      checks++;
      if (in_ready !== 1'b0 || occupancy !== 3'd4) begin
        errors++;
        $display("FAIL full_%0d: ir=%b occ=%0d, want 0 4", rep, in_ready, occupancy);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (occupancy !== 3'd4 || out_flit !== mk(8'h20 + 8'(rep * 4), 4'd3, 4'd3)) begin
        errors++;
        $display("FAIL ignored_push_%0d: occ=%0d head=%h, want 4 %h", rep, occupancy, out_flit,
                 mk(8'h20 + 8'(rep * 4), 4'd3, 4'd3));
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 3'b100 || out_flit !== mk(8'h20 + 8'(rep * 4 + i), 4'd3, 4'd3)) begin
          errors++;
          $display("FAIL drain_%0d_%0d: ov=%b sel=%b flit=%h, want 1 100 %h", rep, i, out_valid,
                   out_sel, out_flit, mk(8'h20 + 8'(rep * 4 + i), 4'd3, 4'd3));
        end
        @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 3'd0 || out_flit !== 16'h0 || out_sel !== 3'b000) begin
        errors++;
        $display("FAIL empty_gate_%0d: ov=%b occ=%0d flit=%h sel=%b, want 0 0 0000 000", rep,
                 out_valid, occupancy, out_flit, out_sel);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_simul_push_pop;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_flit = mk(8'h40 + 8'(i), 4'd0, 4'd3);
    end
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (occupancy !== 3'd2 || out_flit !== mk(8'h40 + 8'(k), 4'd0, 4'd3) || out_sel !== 3'b011) begin
        errors++;
        $display("FAIL simul_%0d: occ=%0d head=%h sel=%b, want 2 %h 011", k, occupancy, out_flit,
                 out_sel, mk(8'h40 + 8'(k), 4'd0, 4'd3));
      end
      in_valid = 1'b1; out_ready = 1'b1; in_flit = mk(8'h42 + 8'(k), 4'd0, 4'd3);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd2 || out_flit !== mk(8'h4A, 4'd0, 4'd3)) begin
      errors++;
      $display("FAIL simul_end: occ=%0d head=%h, want 2 %h", occupancy, out_flit, mk(8'h4A, 4'd0, 4'd3));
    end
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL simul_drain: ov=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pre: ov=%b, want 0", out_valid);
    end
    in_valid = 1'b1; in_flit = mk(8'h80, 4'd7, 4'd3);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || occupancy !== 3'd1 || out_sel !== 3'b001 ||
          out_flit !== mk(8'h80 + 8'(k - 1), 4'd7, 4'd3)) begin
        errors++;
        $display("FAIL b2b_%0d: ov=%b occ=%0d sel=%b flit=%h, want 1 1 001 %h", k, out_valid,
                 occupancy, out_sel, out_flit, mk(8'h80 + 8'(k - 1), 4'd7, 4'd3));
      end
      if (k < 16) in_flit = mk(8'h80 + 8'(k), 4'd7, 4'd3);
      else        in_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      errors++;
      $display("FAIL b2b_end: ov=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_fill_wrap();
    test_simul_push_pop();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
